// File: rtl/nf_i_mdu_pkg.sv
// Shared settings for the RV32M multiply/divide unit: funct3 op codes,
// sequencer states and iteration count.
package nf_i_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam int MDU_ITERS = 32;
    localparam int MDU_CNT_W = $clog2(MDU_ITERS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

endpackage

// File: rtl/nf_mdu_iter.sv
// One combinational iteration of the MDU datapath: radix-2 shift-add for
// multiply, restoring trial-subtract for divide, on {acc, opr}.
module nf_mdu_iter (
    input  logic        is_div,
    input  logic [31:0] acc_i,
    input  logic [31:0] opr_i,
    input  logic [31:0] opd_i,
    output logic [31:0] acc_o,
    output logic [31:0] opr_o
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        ge;

    assign sum     = {1'b0, acc_i} + (opr_i[0] ? {1'b0, opd_i} : 33'd0);
    assign shifted = {acc_i, opr_i[31]};
    assign ge      = (shifted >= {1'b0, opd_i});
    // When ge holds the true difference is below the divisor, so 32 bits suffice.
    assign diff    = shifted[31:0] - opd_i;

    always_comb begin
        acc_o = sum[32:1];
        opr_o = {sum[0], opr_i[31:1]};
        if (is_div) begin
            acc_o = ge ? diff : shifted[31:0];
            opr_o = {opr_i[30:0], ge};
        end
    end

endmodule

// File: rtl/nf_i_mdu.sv
// Iterative RV32M multiply/divide unit: IDLE/CALC/FIX/DONE sequencer, operand
// magnitude decode, sign fix-up and a registered result with a one-cycle strobe.
module nf_i_mdu
    import nf_i_mdu_pkg::*;
#(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        kill,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result
);

    mdu_state_e             state_q, state_d;
    logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]             op_q, op_d;
    logic [31:0]            acc_q, acc_d;
    logic [31:0]            opr_q, opr_d;
    logic [31:0]            opd_q, opd_d;
    logic                   neg_q, neg_d;
    logic [31:0]            result_q, result_d;

    logic        is_div_in;
    logic        a_sgn;
    logic        b_sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_val;
    logic        neg_in;
    logic        accept;

    logic [31:0] iter_acc;
    logic [31:0] iter_opr;
    logic [63:0] product_mag;
    logic [63:0] product;
    logic [31:0] div_mag;
    logic [31:0] div_val;
    logic [31:0] fix_val;

    // Signedness per funct3: DIV/REM signed, MUL/MULH both, MULHSU only A.
    assign is_div_in = op[2];
    assign a_sgn     = is_div_in ? ~op[0] : (op[1:0] != 2'b11);
    assign b_sgn     = is_div_in ? ~op[0] : ~op[1];
    assign a_neg     = a_sgn & srcA[31];
    assign b_neg     = b_sgn & srcB[31];
    assign mag_a     = a_neg ? (~srcA + 32'd1) : srcA;
    assign mag_b     = b_neg ? (~srcB + 32'd1) : srcB;

    assign div_zero  = is_div_in & (srcB == 32'd0);
    assign div_ovf   = is_div_in & ~op[0] & (srcA == 32'h8000_0000) & (srcB == 32'hFFFF_FFFF);
    assign special   = div_zero | div_ovf;

    always_comb begin
        special_val = 32'h8000_0000;
        if (div_zero) begin
            special_val = op[1] ? srcA : 32'hFFFF_FFFF;
        end else if (op[1]) begin
            special_val = 32'd0;
        end
    end

    // A zero divisor must leave the all-ones quotient un-negated.
    always_comb begin
        neg_in = a_neg ^ b_neg;
        if (is_div_in) begin
            neg_in = op[1] ? a_neg : ((a_neg ^ b_neg) & ~div_zero);
        end
    end

    assign accept = (state_q == ST_IDLE) & req & ~kill;
    assign busy   = accept | (state_q == ST_CALC) | (state_q == ST_FIX);
    assign valid  = (state_q == ST_DONE);
    assign result = result_q;

    nf_mdu_iter u_iter (
        .is_div (op_q[2]),
        .acc_i  (acc_q),
        .opr_i  (opr_q),
        .opd_i  (opd_q),
        .acc_o  (iter_acc),
        .opr_o  (iter_opr)
    );

    assign product_mag = {acc_q, opr_q};
    assign product     = neg_q ? (~product_mag + 64'd1) : product_mag;
    assign div_mag     = op_q[1] ? acc_q : opr_q;
    assign div_val     = neg_q ? (~div_mag + 32'd1) : div_mag;

    always_comb begin
        fix_val = product[63:32];
        if (op_q[2]) begin
            fix_val = div_val;
        end else if (op_q == MDU_MUL) begin
            fix_val = product[31:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opr_d    = opr_q;
        opd_d    = opd_q;
        neg_d    = neg_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    op_d  = op;
                    acc_d = 32'd0;
                    opr_d = is_div_in ? mag_a : mag_b;
                    opd_d = is_div_in ? mag_b : mag_a;
                    neg_d = neg_in;
                    if (EARLY_OUT && special) begin
                        state_d  = ST_DONE;
                        result_d = special_val;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = iter_acc;
                opr_d = iter_opr;
                cnt_d = cnt_q + MDU_CNT_W'(1);
                if (cnt_q == MDU_CNT_W'(MDU_ITERS - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fix_val;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush abandons the operation and leaves the last result visible.
        if (kill) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= 3'd0;
            acc_q    <= 32'd0;
            opr_q    <= 32'd0;
            opd_q    <= 32'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opr_q    <= opr_d;
            opd_q    <= opd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_nf_i_mdu.sv
// Testbench for nf_i_mdu: one early-out and one fully iterative instance,
// checked against an arithmetic RV32M reference model.
module tb_nf_i_mdu;

    logic        clk;
    logic        rst;
    logic        req_v  [2];
    logic [2:0]  op_v   [2];
    logic [31:0] a_v    [2];
    logic [31:0] b_v    [2];
    logic        kill_v [2];
    logic        busy_v [2];
    logic        valid_v[2];
    logic [31:0] res_v  [2];

    int          n_cmp;
    int          n_fail;
    int          valid_cnt[2];
    int          exp_valid[2];
    logic [31:0] prev_res [2];

    nf_i_mdu #(.EARLY_OUT(1'b1)) u_dut_e (
        .clk    (clk),
        .rst    (rst),
        .req    (req_v[0]),
        .op     (op_v[0]),
        .srcA   (a_v[0]),
        .srcB   (b_v[0]),
        .kill   (kill_v[0]),
        .busy   (busy_v[0]),
        .valid  (valid_v[0]),
        .result (res_v[0])
    );

    nf_i_mdu #(.EARLY_OUT(1'b0)) u_dut_i (
        .clk    (clk),
        .rst    (rst),
        .req    (req_v[1]),
        .op     (op_v[1]),
        .srcA   (a_v[1]),
        .srcB   (b_v[1]),
        .kill   (kill_v[1]),
        .busy   (busy_v[1]),
        .valid  (valid_v[1]),
        .result (res_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_v[0] === 1'b1) valid_cnt[0]++;
        if (valid_v[1] === 1'b1) valid_cnt[1]++;
    end

    // RV32M semantics straight from the ISA rules, using 64-bit arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input int s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit spec_case;
        spec_case = o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return (s == 0 && spec_case) ? 1 : 34;
    endfunction

    task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input bit hold, input bit jitter,
                          input string tag);
        int k;
        bit done;
        @(negedge clk);
        req_v[s] = 1'b1;
        op_v[s]  = o;
        a_v[s]   = a;
        b_v[s]   = b;
        exp_valid[s]++;
        #1;
        k    = 0;
        done = 1'b0;
        while (!done && k <= 40) begin
            if (valid_v[s] === 1'b1) begin
                done = 1'b1;
                n_cmp += 3;
                if (k !== exp_lat) begin
                    n_fail++;
                    $display("[TB] FAIL %s latency (dut%0d): got %0d cycles, expected %0d", tag, s, k, exp_lat);
                end
                if (res_v[s] !== exp_res) begin
                    n_fail++;
                    $display("[TB] FAIL %s result (dut%0d): got %h, expected %h", tag, s, res_v[s], exp_res);
                end
                if (busy_v[s] !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL %s busy in valid cycle (dut%0d): got %b, expected 0", tag, s, busy_v[s]);
                end
                prev_res[s] = exp_res;
                if (!hold) req_v[s] = 1'b0;
            end else begin
                n_cmp++;
                if (busy_v[s] !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL %s busy cycle %0d (dut%0d): got %b, expected 1", tag, k, s, busy_v[s]);
                end
                @(negedge clk);
                k++;
                if (jitter) begin
                    if (k < 31) begin
                        req_v[s] = 1'($urandom);
                        op_v[s]  = 3'($urandom);
                        a_v[s]   = $urandom;
                        b_v[s]   = $urandom;
                    end else begin
                        req_v[s] = 1'b1;
                        op_v[s]  = o;
                        a_v[s]   = a;
                        b_v[s]   = b;
                    end
                end
                #1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s timeout (dut%0d): no valid after %0d cycles, expected at %0d", tag, s, k, exp_lat);
            req_v[s]    = 1'b0;
            prev_res[s] = exp_res;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            n_cmp += 3;
            if (busy_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy (dut%0d): got %b, expected 0", s, busy_v[s]); end
            if (valid_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset valid (dut%0d): got %b, expected 0", s, valid_v[s]); end
            if (res_v[s] !== 32'd0) begin n_fail++; $display("[TB] FAIL reset result (dut%0d): got %h, expected 0", s, res_v[s]); end
            prev_res[s] = 32'd0;
        end
        rst = 1'b0;
    endtask

    task automatic test_directed(input int s);
        logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                  32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exs [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          lts [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            run_op(s, ops[i], as[i], bs[i], exs[i], (s == 0) ? lts[i] : 34, 1'b0, 1'b0, $sformatf("directed%0d", i));
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (res_v[s] !== prev_res[s]) begin
            n_fail++;
            $display("[TB] FAIL result hold (dut%0d): got %h, expected %h", s, res_v[s], prev_res[s]);
        end
    endtask

    task automatic test_kill(input int s);
        @(negedge clk);
        req_v[s] = 1'b1;
        op_v[s]  = 3'd0;
        a_v[s]   = 32'h1234_5678;
        b_v[s]   = 32'h0BAD_F00D;
        exp_valid[s]++;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) kill_v[s] = 1'b1;
            #1;
            n_cmp++;
            if (valid_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL kill early valid cycle %0d (dut%0d): got %b, expected 0", k, s, valid_v[s]); end
        end
        exp_valid[s]--;
        @(negedge clk);
        kill_v[s] = 1'b0;
        req_v[s]  = 1'b0;
        #1;
        n_cmp += 3;
        if (busy_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL kill busy (dut%0d): got %b, expected 0", s, busy_v[s]); end
        if (valid_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL kill valid (dut%0d): got %b, expected 0", s, valid_v[s]); end
        if (res_v[s] !== prev_res[s]) begin n_fail++; $display("[TB] FAIL kill result (dut%0d): got %h, expected %h", s, res_v[s], prev_res[s]); end
        run_op(s, 3'd0, 32'd3, 32'd4, 32'd12, 34, 1'b0, 1'b0, "after_kill");
        // A request raised together with kill in IDLE must not be taken.
        @(negedge clk);
        req_v[s]  = 1'b1;
        kill_v[s] = 1'b1;
        #1;
        n_cmp++;
        if (busy_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL req_with_kill busy (dut%0d): got %b, expected 0", s, busy_v[s]); end
        @(negedge clk);
        req_v[s]  = 1'b0;
        kill_v[s] = 1'b0;
        #1;
        n_cmp++;
        if (busy_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL req_with_kill accepted (dut%0d): got busy %b, expected 0", s, busy_v[s]); end
    endtask

    task automatic test_back_to_back();
        run_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1, 1'b0, "b2b_a");
        run_op(0, 3'd0, 32'd3, 32'd5, 32'd15, 34, 1'b1, 1'b0, "b2b_b");
        run_op(0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, "b2b_c");
        run_op(0, 3'd7, 32'd9, 32'd0, 32'd9, 1, 1'b1, 1'b0, "b2b_d");
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, 1'b0, "b2b_e");
        run_op(1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b1, 1'b0, "b2b_f");
        run_op(1, 3'd3, 32'hFFFF_FFFF, 32'd2, 32'd1, 34, 1'b0, 1'b0, "b2b_g");
    endtask

    task automatic test_calc_req_ignored();
        run_op(0, 3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, ref_mdu(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF), 34, 1'b0, 1'b1, "jitter_a");
        run_op(1, 3'd6, 32'hF000_0001, 32'd13, ref_mdu(3'd6, 32'hF000_0001, 32'd13), 34, 1'b0, 1'b1, "jitter_b");
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 30; i++) begin
                o   = 3'($urandom_range(0, 7));
                a   = $urandom;
                b   = $urandom;
                sel = $urandom_range(0, 9);
                if (sel == 0) b = 32'd0;
                if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                if (sel == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
                if (sel == 3) b = -($urandom_range(1, 9));
                run_op(s, o, a, b, ref_mdu(o, a, b), ref_latency(s, o, a, b),
                       1'($urandom_range(0, 1)), (ref_latency(s, o, a, b) == 34) && ($urandom_range(0, 3) == 0),
                       $sformatf("rand%0d_op%0d", i, o));
            end
            @(negedge clk);
            req_v[s] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        req_v[0] = 1'b1;
        op_v[0]  = 3'd4;
        a_v[0]   = 32'h7654_3210;
        b_v[0]   = 32'd3;
        exp_valid[0]++;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 20) rst = 1'b1;
        end
        exp_valid[0]--;
        @(negedge clk);
        rst      = 1'b0;
        req_v[0] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            n_cmp += 3;
            if (busy_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid busy (dut%0d): got %b, expected 0", s, busy_v[s]); end
            if (valid_v[s] !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid valid (dut%0d): got %b, expected 0", s, valid_v[s]); end
            if (res_v[s] !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_mid result (dut%0d): got %h, expected 0", s, res_v[s]); end
            prev_res[s] = 32'd0;
        end
        repeat (40) @(negedge clk);
        run_op(0, 3'd7, 32'd1000, 32'd7, 32'd6, 34, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_valid_count();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if (valid_cnt[s] !== exp_valid[s]) begin
                n_fail++;
                $display("[TB] FAIL valid count (dut%0d): got %0d strobes, expected %0d", s, valid_cnt[s], exp_valid[s]);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_v[s]     = 1'b0;
            op_v[s]      = 3'd0;
            a_v[s]       = 32'd0;
            b_v[s]       = 32'd0;
            kill_v[s]    = 1'b0;
            valid_cnt[s] = 0;
            exp_valid[s] = 0;
            prev_res[s]  = 32'd0;
        end
        test_reset();
        test_directed(0);
        test_directed(1);
        test_kill(0);
        test_kill(1);
        test_back_to_back();
        test_calc_req_ignored();
        test_random();
        test_reset_mid_calc();
        test_valid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global timeout: simulation did not complete, expected completion before 2000000");
        $fatal(1, "[TB] timeout");
    end

endmodule
